// File: rtl/rv_defs_pkg.sv
// Shared RISC-V definitions for the writeback path.
// Holds the opcodes that retire through writeback, the load access-size encodings
// carried in funct3[1:0], and a helper that decides whether an opcode writes rd.
package rv_defs_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;

  // funct3[1:0] access size; funct3[2] selects zero-extension
  localparam logic [1:0] MEM_ACC_8  = 2'b00;
  localparam logic [1:0] MEM_ACC_16 = 2'b01;
  localparam logic [1:0] MEM_ACC_32 = 2'b10;

  function automatic logic op_writes_rd(input logic [6:0] op);
    return op inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP_IMM, OPC_OP, OPC_LOAD};
  endfunction

endpackage

// File: rtl/regfile_wb_if.sv
// Writeback / issue / read-port bundle of the register file.
// master: retire, issue and read-address side. slave: the register file.
//   wb_*     retiring result (always accepted), wb_ack / wb_misalign returned
//   iss_*    destination reservation for the scoreboard
//   rs_*     packed read ports with combinational data and busy flags
interface regfile_wb_if #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned READ_PORTS     = 2
);
  logic                                 wb_valid;
  logic [6:0]                           wb_op;
  logic [2:0]                           wb_funct3;
  logic [REG_ADDR_WIDTH-1:0]            wb_rd;
  logic [1:0]                           wb_byte_off;
  logic [XLEN-1:0]                      wb_val;
  logic                                 iss_valid;
  logic [REG_ADDR_WIDTH-1:0]            iss_rd;
  logic [READ_PORTS*REG_ADDR_WIDTH-1:0] rs_addr;
  logic [READ_PORTS*XLEN-1:0]           rs_data;
  logic [READ_PORTS-1:0]                rs_busy;
  logic                                 wb_ack;
  logic                                 wb_misalign;

  modport master (
    output wb_valid, wb_op, wb_funct3, wb_rd, wb_byte_off, wb_val, iss_valid, iss_rd, rs_addr,
    input  rs_data, rs_busy, wb_ack, wb_misalign
  );

  modport slave (
    input  wb_valid, wb_op, wb_funct3, wb_rd, wb_byte_off, wb_val, iss_valid, iss_rd, rs_addr,
    output rs_data, rs_busy, wb_ack, wb_misalign
  );
endinterface

// File: rtl/load_align.sv
// Combinational load extraction from a raw aligned memory word.
//   value_i     raw memory word
//   funct3_i    [1:0] access size, [2] zero-extend
//   byte_off_i  low address bits of the access
//   aligned_o   extracted and extended result
//   misalign_o  half at an odd offset, or word at a non-zero offset
module load_align
  import rv_defs_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] value_i,
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      byte_off_i,
  output logic [XLEN-1:0] aligned_o,
  output logic            misalign_o
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sext;

  always_comb begin
    byte_sel   = value_i[{byte_off_i, 3'b000} +: 8];
    half_sel   = value_i[{byte_off_i[1], 4'b0000} +: 16];
    sext       = ~funct3_i[2];
    aligned_o  = value_i;
    misalign_o = 1'b0;
    case (funct3_i[1:0])
      MEM_ACC_8:  aligned_o = {{(XLEN-8){sext & byte_sel[7]}}, byte_sel};
      MEM_ACC_16: begin
        aligned_o  = {{(XLEN-16){sext & half_sel[15]}}, half_sel};
        misalign_o = byte_off_i[0];
      end
      // word, and the unused size 2'b11 treated like a word
      default:    misalign_o = (byte_off_i != 2'b00);
    endcase
  end

endmodule

// File: rtl/regfile_wb.sv
// Register file with a two-stage writeback pipeline and a busy scoreboard.
//   clk, rst  rising-edge clock, synchronous active-high reset
//   bus       regfile_wb_if slave: writeback request, issue reservation, read ports,
//             wb_ack / wb_misalign pulses one cycle after commit
//   regs      packed debug view, register i at [XLEN*i +: XLEN]
// S1 captures the request and aligns loads; S2 commits on the following edge.
module regfile_wb
  import rv_defs_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned REG_CNT        = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned READ_PORTS     = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  regfile_wb_if.slave             bus,
  output logic [REG_CNT*XLEN-1:0] regs
);
  // S1
  logic                      s1_valid_q;
  logic [6:0]                s1_op_q;
  logic [2:0]                s1_funct3_q;
  logic [REG_ADDR_WIDTH-1:0] s1_rd_q;
  logic [1:0]                s1_off_q;
  logic [XLEN-1:0]           s1_val_q;
  logic [XLEN-1:0]           s1_aligned;
  logic                      s1_misalign;
  logic                      s1_is_load;

  // S2
  logic                      s2_valid_q;
  logic                      s2_we_q, s2_we_d;
  logic                      s2_mis_q, s2_mis_d;
  logic [REG_ADDR_WIDTH-1:0] s2_rd_q;
  logic [XLEN-1:0]           s2_val_q, s2_val_d;

  logic                      wb_ack_q, wb_misalign_q;
  logic [XLEN-1:0]           rf_q [REG_CNT];
  logic [REG_CNT-1:0]        busy_q, busy_d;
  logic [REG_ADDR_WIDTH-1:0] rd_addr;
  logic                      rd_hit;

  load_align #(.XLEN(XLEN)) u_load_align (
    .value_i    (s1_val_q),
    .funct3_i   (s1_funct3_q),
    .byte_off_i (s1_off_q),
    .aligned_o  (s1_aligned),
    .misalign_o (s1_misalign)
  );

  assign s1_is_load = (s1_op_q == OPC_LOAD);
  assign s2_mis_d   = s1_is_load & s1_misalign;
  // rd=0 and misaligned loads still flow to S2 for the ack, they just never write
  assign s2_we_d    = op_writes_rd(s1_op_q) & ~s2_mis_d & (s1_rd_q != '0);
  assign s2_val_d   = s1_is_load ? s1_aligned : s1_val_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s2_valid_q    <= 1'b0;
      wb_ack_q      <= 1'b0;
      wb_misalign_q <= 1'b0;
    end else begin
      s1_valid_q    <= bus.wb_valid;
      s2_valid_q    <= s1_valid_q;
      wb_ack_q      <= s2_valid_q;
      wb_misalign_q <= s2_valid_q & s2_mis_q;
    end
    s1_op_q     <= bus.wb_op;
    s1_funct3_q <= bus.wb_funct3;
    s1_rd_q     <= bus.wb_rd;
    s1_off_q    <= bus.wb_byte_off;
    s1_val_q    <= bus.wb_val;
    s2_we_q     <= s2_we_d;
    s2_mis_q    <= s2_mis_d;
    s2_rd_q     <= s1_rd_q;
    s2_val_q    <= s2_val_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < REG_CNT; i++) rf_q[i] <= '0;
    end else if (s2_valid_q && s2_we_q) begin
      rf_q[s2_rd_q] <= s2_val_q;
    end
  end

  // Clear first, then set, so a same-edge issue to the committing rd stays busy
  always_comb begin
    busy_d = busy_q;
    if (s2_valid_q) busy_d[s2_rd_q] = 1'b0;
    if (bus.iss_valid && (bus.iss_rd != '0)) busy_d[bus.iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  // Read ports see the committing S2 value and its busy clear, not same-cycle issues
  always_comb begin
    bus.rs_data = '0;
    bus.rs_busy = '0;
    rd_addr     = '0;
    rd_hit      = 1'b0;
    for (int unsigned p = 0; p < READ_PORTS; p++) begin
      rd_addr = bus.rs_addr[p*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
      rd_hit  = s2_valid_q && (s2_rd_q == rd_addr);
      bus.rs_data[p*XLEN +: XLEN] = (rd_hit && s2_we_q) ? s2_val_q : rf_q[rd_addr];
      bus.rs_busy[p] = busy_q[rd_addr] & ~rd_hit;
    end
  end

  always_comb begin
    regs = '0;
    for (int unsigned i = 0; i < REG_CNT; i++) regs[i*XLEN +: XLEN] = rf_q[i];
  end

  assign bus.wb_ack      = wb_ack_q;
  assign bus.wb_misalign = wb_misalign_q;

endmodule

// File: tb/tb_regfile_wb.sv
// Self-checking bench for regfile_wb: a queue-based model of retiring results is
// compared against the DUT every cycle, plus directed literal checks.
module tb_regfile_wb;
  logic                clk = 1'b0;
  logic                rst;
  logic [32*32-1:0]    regs;
  int                  total = 0;
  int                  bad   = 0;

  regfile_wb_if #(.XLEN(32), .REG_ADDR_WIDTH(5), .READ_PORTS(2)) bus ();

  regfile_wb #(
    .XLEN(32), .REG_CNT(32), .REG_ADDR_WIDTH(5), .READ_PORTS(2)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .regs (regs)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LUI = 7'b0110111, OPIMM = 7'b0010011, OP = 7'b0110011;
  localparam logic [6:0] LOAD = 7'b0000011, BRANCH = 7'b1100011;

  // ---------------- model ----------------
  typedef struct {
    int          due;
    logic [4:0]  rd;
    logic        we;
    logic        mis;
    logic [31:0] val;
  } wb_rec_t;

  wb_rec_t     pend[$];
  logic [31:0] m_regs [32];
  logic [31:0] m_busy;
  logic        m_ack, m_mis;
  bit          model_on = 0;
  int          k = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Result of a retiring instruction from the ISA rules
  function automatic wb_rec_t eval_wb(input logic [6:0] op, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [1:0] off,
                                      input logic [31:0] v);
    wb_rec_t     r;
    int unsigned x;
    bit          writes;
    writes = (op == 7'h37) || (op == 7'h17) || (op == 7'h6F) || (op == 7'h67) ||
             (op == 7'h13) || (op == 7'h33) || (op == 7'h03);
    r.rd  = rd;
    r.val = v;
    r.mis = 1'b0;
    r.due = 0;
    if (op == 7'h03) begin
      if (f3[1:0] == 2'd0) begin
        x = (v >> (8 * off)) & 32'hFF;
        if (!f3[2] && x >= 128) x = x + 32'hFFFFFF00;
        r.val = x;
      end else if (f3[1:0] == 2'd1) begin
        r.mis = (off % 2) != 0;
        x = (v >> (16 * (off / 2))) & 32'hFFFF;
        if (!f3[2] && x >= 32768) x = x + 32'hFFFF0000;
        r.val = x;
      end else begin
        r.mis = (off != 0);
      end
    end
    r.we = writes && !r.mis && (rd != 0);
    return r;
  endfunction

  always @(posedge clk) begin
    wb_rec_t r;
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_busy = '0;
      pend.delete();
      m_ack = 1'b0;
      m_mis = 1'b0;
      k = 0;
      model_on = 1;
    end else if (model_on) begin
      k++;
      m_ack = 1'b0;
      m_mis = 1'b0;
      if (pend.size() > 0 && pend[0].due == k) begin
        r = pend.pop_front();
        if (r.we) m_regs[r.rd] = r.val;
        m_busy[r.rd] = 1'b0;
        m_ack = 1'b1;
        m_mis = r.mis;
      end
      if (bus.iss_valid && bus.iss_rd != 0) m_busy[bus.iss_rd] = 1'b1;
      if (bus.wb_valid) begin
        r = eval_wb(bus.wb_op, bus.wb_funct3, bus.wb_rd, bus.wb_byte_off, bus.wb_val);
        r.due = k + 2;
        pend.push_back(r);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (model_on) begin
      logic [4:0]  a;
      logic        cm;
      logic [31:0] ed;
      logic        eb;
      int          first_bad;
      chk("ack", {31'd0, bus.wb_ack}, {31'd0, m_ack});
      chk("misalign", {31'd0, bus.wb_misalign}, {31'd0, m_mis});
      first_bad = -1;
      for (int i = 31; i >= 0; i--) if (regs[i*32 +: 32] !== m_regs[i]) first_bad = i;
      total++;
      if (first_bad >= 0) begin
        bad++;
        $display("FAIL regs[%0d]: got %h expected %h (t=%0t)", first_bad,
                 regs[first_bad*32 +: 32], m_regs[first_bad], $time);
      end
      for (int p = 0; p < 2; p++) begin
        a  = bus.rs_addr[p*5 +: 5];
        cm = pend.size() > 0 && pend[0].due == k + 1 && pend[0].rd == a;
        ed = (cm && pend[0].we) ? pend[0].val : m_regs[a];
        eb = m_busy[a] && !cm;
        chk($sformatf("rs_data[%0d]", p), bus.rs_data[p*32 +: 32], ed);
        chk($sformatf("rs_busy[%0d]", p), {31'd0, bus.rs_busy[p]}, {31'd0, eb});
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                    input logic [1:0] off, input logic [31:0] v);
    bus.wb_valid    = 1'b1;
    bus.wb_op       = op;
    bus.wb_funct3   = f3;
    bus.wb_rd       = rd;
    bus.wb_byte_off = off;
    bus.wb_val      = v;
  endtask

  task automatic iss(input logic v, input logic [4:0] rd);
    bus.iss_valid = v;
    bus.iss_rd    = rd;
  endtask

  function automatic logic [31:0] reg_of(input int i);
    return regs[i*32 +: 32];
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.wb_valid = 1'b0; bus.wb_op = '0; bus.wb_funct3 = '0; bus.wb_rd = '0;
    bus.wb_byte_off = '0; bus.wb_val = '0; bus.iss_valid = 1'b0; bus.iss_rd = '0;
    bus.rs_addr = '0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_ack", {31'd0, bus.wb_ack}, 32'd0);
    chk("reset_reg5", reg_of(5), 32'd0);

    // Plain ALU result, two-edge latency
    wb(OPIMM, 3'b000, 5'd5, 2'd0, 32'h1234_5678); tick(); bus.wb_valid = 1'b0;
    chk("t1_ack_e0", {31'd0, bus.wb_ack}, 32'd0);
    tick();
    chk("t1_ack_e1", {31'd0, bus.wb_ack}, 32'd0);
    tick();
    chk("t1_ack", {31'd0, bus.wb_ack}, 32'd1);
    chk("t1_mis", {31'd0, bus.wb_misalign}, 32'd0);
    chk("t1_reg5", reg_of(5), 32'h1234_5678);

    // Back-to-back loads of each size
    wb(LOAD, 3'b000, 5'd6, 2'd2, 32'h0080_0000); tick();
    wb(LOAD, 3'b100, 5'd8, 2'd2, 32'h0080_0000); tick();
    wb(LOAD, 3'b001, 5'd10, 2'd2, 32'h8001_0000); tick();
    chk("lb_reg6", reg_of(6), 32'hFFFF_FF80);
    wb(LOAD, 3'b101, 5'd11, 2'd2, 32'h8001_0000); tick();
    chk("lbu_reg8", reg_of(8), 32'h0000_0080);
    wb(LOAD, 3'b010, 5'd12, 2'd0, 32'hDEAD_BEEF); tick();
    chk("lh_reg10", reg_of(10), 32'hFFFF_8001);
    bus.wb_valid = 1'b0; tick();
    chk("lhu_reg11", reg_of(11), 32'h0000_8001);
    tick();
    chk("lw_reg12", reg_of(12), 32'hDEAD_BEEF);

    // Misaligned half clears busy without writing
    bus.rs_addr = {5'd7, 5'd0};
    iss(1'b1, 5'd7); tick(); iss(1'b0, 5'd0);
    chk("t3_busy_set", {31'd0, bus.rs_busy[1]}, 32'd1);
    wb(LOAD, 3'b001, 5'd7, 2'd1, 32'h1234_5678); tick(); bus.wb_valid = 1'b0;
    tick();
    chk("t3_busy_commit", {31'd0, bus.rs_busy[1]}, 32'd0);
    tick();
    chk("t3_ack", {31'd0, bus.wb_ack}, 32'd1);
    chk("t3_mis", {31'd0, bus.wb_misalign}, 32'd1);
    chk("t3_reg7", reg_of(7), 32'd0);
    chk("t3_busy_after", {31'd0, bus.rs_busy[1]}, 32'd0);
    wb(LOAD, 3'b010, 5'd13, 2'd2, 32'h1111_1111); tick(); bus.wb_valid = 1'b0;
    tick(); tick();
    chk("t3w_mis", {31'd0, bus.wb_misalign}, 32'd1);
    chk("t3w_reg13", reg_of(13), 32'd0);

    // Bypass during commit cycle
    bus.rs_addr = {5'd0, 5'd3};
    iss(1'b1, 5'd3); tick(); iss(1'b0, 5'd0);
    chk("t4_busy_set", {31'd0, bus.rs_busy[0]}, 32'd1);
    wb(OP, 3'b000, 5'd3, 2'd0, 32'hCAFE_BABE); tick(); bus.wb_valid = 1'b0;
    tick();
    chk("t4_bypass_data", bus.rs_data[31:0], 32'hCAFE_BABE);
    chk("t4_bypass_busy", {31'd0, bus.rs_busy[0]}, 32'd0);
    chk("t4_reg3_old", reg_of(3), 32'd0);
    tick();
    chk("t4_reg3", reg_of(3), 32'hCAFE_BABE);

    // Issue and commit of the same rd on one edge: set wins
    bus.rs_addr = {5'd0, 5'd9};
    wb(LUI, 3'b000, 5'd9, 2'd0, 32'h0000_0099); tick(); bus.wb_valid = 1'b0;
    tick();
    iss(1'b1, 5'd9); tick(); iss(1'b0, 5'd0);
    chk("t5_reg9", reg_of(9), 32'h0000_0099);
    chk("t5_busy9", {31'd0, bus.rs_busy[0]}, 32'd1);
    bus.rs_addr = {5'd0, 5'd0};
    wb(OP, 3'b000, 5'd0, 2'd0, 32'hFFFF_FFFF); tick(); bus.wb_valid = 1'b0;
    tick(); tick();
    chk("t5_ack_x0", {31'd0, bus.wb_ack}, 32'd1);
    chk("t5_reg0", reg_of(0), 32'd0);
    chk("t5_rs_x0", bus.rs_data[31:0], 32'd0);
    wb(BRANCH, 3'b000, 5'd14, 2'd0, 32'h0000_0055); tick(); bus.wb_valid = 1'b0;
    tick(); tick();
    chk("t5_branch_ack", {31'd0, bus.wb_ack}, 32'd1);
    chk("t5_branch_reg14", reg_of(14), 32'd0);

    // Reset with both stages full
    iss(1'b1, 5'd15); tick(); iss(1'b0, 5'd0);
    wb(OPIMM, 3'b000, 5'd16, 2'd0, 32'd1); tick();
    wb(OPIMM, 3'b000, 5'd17, 2'd0, 32'd2); tick();
    rst = 1'b1;
    wb(OPIMM, 3'b000, 5'd18, 2'd0, 32'd3); iss(1'b1, 5'd19); tick();
    rst = 1'b0; bus.wb_valid = 1'b0; iss(1'b0, 5'd0);
    bus.rs_addr = {5'd19, 5'd15};
    chk("t6_ack0", {31'd0, bus.wb_ack}, 32'd0);
    chk("t6_reg5", reg_of(5), 32'd0);
    chk("t6_reg16", reg_of(16), 32'd0);
    tick();
    chk("t6_ack1", {31'd0, bus.wb_ack}, 32'd0);
    chk("t6_reg17", reg_of(17), 32'd0);
    tick();
    chk("t6_ack2", {31'd0, bus.wb_ack}, 32'd0);
    chk("t6_reg18", reg_of(18), 32'd0);
    chk("t6_busy15", {31'd0, bus.rs_busy[0]}, 32'd0);
    chk("t6_busy19", {31'd0, bus.rs_busy[1]}, 32'd0);
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb.md
REGFILE_WB -- requirements
Module: regfile_wb

Interface
REQ-001 Parameter XLEN, default 32, register and datapath width in bits.
REQ-002 Parameter REG_CNT, default 32, number of architectural registers.
REQ-003 Parameter REG_ADDR_WIDTH, default 5, register address width.
REQ-004 Parameter READ_PORTS, default 2, number of independent read ports.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 wb_valid  in  1  writeback request present this cycle; always accepted, no backpressure.
REQ-008 wb_op  in  7  RV opcode of retiring instruction.
REQ-009 wb_funct3  in  3  funct3 of retiring instruction; [1:0] access size, [2] unsigned load.
REQ-010 wb_rd  in  REG_ADDR_WIDTH  destination register.
REQ-011 wb_byte_off  in  2  low address bits of load access.
REQ-012 wb_val  in  XLEN  result, or raw aligned memory word for loads.
REQ-013 iss_valid  in  1  instruction issued this cycle, reserving iss_rd.
REQ-014 iss_rd  in  REG_ADDR_WIDTH  destination being reserved.
REQ-015 rs_addr  in  READ_PORTS*REG_ADDR_WIDTH  packed read addresses.
REQ-016 rs_data  out  READ_PORTS*XLEN  packed read data, combinational.
REQ-017 rs_busy  out  READ_PORTS  per-port pending-write flag, combinational.
REQ-018 wb_ack  out  1  one-cycle pulse when a write commits (or is suppressed).
REQ-019 wb_misalign  out  1  one-cycle pulse, coincident with wb_ack, for misaligned load.
REQ-020 regs  out  REG_CNT*XLEN  packed register file for debug, register i at bits [XLEN*i +: XLEN].

Function
REQ-021 Two-stage pipeline shall be used: S1 captures request and performs load alignment; S2 commits to the register file; commit occurs on the second rising edge after wb_valid is sampled, and wb_ack is asserted in the cycle after commit.
REQ-022 Writing ops shall be LUI, AUIPC, JAL, JALR, OP-IMM, OP, LOAD; other ops shall produce wb_ack but no write.
REQ-023 Loads: byte shall take bits [8*off +: 8]; half shall take bits [16*off[1] +: 16]; word shall take whole value; sign-extend unless funct3[2]=1.
REQ-024 Half with off[0]=1, or word with off!=0, shall suppress the write and pulse wb_misalign with wb_ack; busy for rd is still cleared.
REQ-025 Writes to register 0 shall be discarded; register 0 shall always read 0 and never be busy.
REQ-026 Read ports shall bypass: when S2 commits to address A in the current cycle, reads of A shall return the committing value; otherwise, they shall return stored contents.
REQ-027 Scoreboard: iss_valid with iss_rd!=0 shall set busy[iss_rd] next edge; S2 commit or suppression shall clear busy[rd].
REQ-028 Simultaneous set and clear of the same register shall leave busy set.
REQ-029 rs_busy[p] shall reflect busy[rs_addr[p]] after applying the same-cycle S2 clear, but not the same-cycle set.
REQ-030 Back-to-back wb_valid every cycle shall sustain one commit per cycle in order.

Reset
REQ-031 rst shall zero all registers, all busy bits, S1/S2 valid flags, wb_ack, and wb_misalign on the next edge.
REQ-032 A request in S1 or S2 when rst is sampled shall be dropped without commit or ack.
REQ-033 Inputs sampled in the reset cycle shall be ignored.

Structure
REQ-034 Opcode constants and MEM_ACC_8/16/32 encodings shall live in shared package rv_defs_pkg.
REQ-035 Load extraction shall be the combinational sub-module load_align (inputs: value, funct3, byte_off; outputs: aligned value, misalign).

Verification
REQ-036 OP-IMM rd=5 val=0x1234_5678 -> wb_ack 2 cycles later, regs[5]=0x12345678.
REQ-037 LOAD byte signed, off=2, val=0x00_80_00_00 -> rd=0xFFFFFF80; same with funct3=100 -> 0x00000080.
REQ-038 LOAD half, off=1, rd=7 -> wb_misalign=1 with wb_ack, regs[7] unchanged, busy[7]=0.
REQ-039 iss rd=3, then commit to rd=3 while rs_addr[0]=3 -> rs_data[0]=new value and rs_busy[0]=0 in the commit cycle.
REQ-040 Issue rd=9 in the same cycle as commit to rd=9 -> busy[9]=1 afterwards; write to rd=0 -> regs[0]=0.
REQ-041 rst asserted with both stages full -> no ack, all regs 0, all busy 0.
